// File: rtl/keypad_pkg.sv
// Shared keypad types and helpers: key geometry, encoder FSM states, priority/multi-press helpers.
package keypad_pkg;

  localparam int NKEYS = 16;
  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld,
    StRelease
  } kp_state_e;

  function automatic logic [KEY_W-1:0] lowest_set_index(input logic [NKEYS-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [NKEYS-1:0] v);
    return (v & (v - NKEYS'(1))) != '0;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent level signals; async reset clears both stages.
module sync_2ff #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage1_q;
  logic [Width-1:0] stage2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/keypad_encoder.sv
// Debounced 16-cell keypad to 4-bit key event encoder with valid/ready output.
// Define KEYPAD_ENCODER_KEY_REPEAT_EN to re-emit the held key every REPEAT_CYCLES.
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] cells,
  input  logic             key_ready,
  output logic             key_valid,
  output logic [KEY_W-1:0] key,
  output logic             multi,
  output logic             busy
);

  localparam int unsigned MaxCycles = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ?
                                      DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] DebTerm = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] sync;
  kp_state_e        state_q, state_d;
  logic [NKEYS-1:0] latch_q, latch_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             multi_q, multi_d;
  logic             emit;
  logic             load_key;

  sync_2ff #(
    .Width(NKEYS)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (cells),
    .q  (sync)
  );

`ifdef KEYPAD_ENCODER_KEY_REPEAT_EN
  localparam logic [CntW-1:0] RepTerm = CntW'(REPEAT_CYCLES - 1);
  logic [CntW-1:0] rcnt_q, rcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    load_key = 1'b0;
`ifdef KEYPAD_ENCODER_KEY_REPEAT_EN
    rcnt_d   = '0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (sync != '0) begin
          latch_d = sync;
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (sync == '0) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (sync != latch_q) begin
          latch_d = sync;
          cnt_d   = '0;
        end else if (cnt_q < DebTerm) begin
          cnt_d = cnt_q + CntW'(1);
        end else if (!valid_q) begin
          // Terminal count with a free output slot; otherwise stall with cnt held.
          emit     = 1'b1;
          load_key = 1'b1;
          cnt_d    = '0;
          state_d  = StHeld;
        end
      end
      StHeld: begin
        if (sync == '0) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
`ifdef KEYPAD_ENCODER_KEY_REPEAT_EN
        else if (rcnt_q == RepTerm) begin
          if (!valid_q) emit = 1'b1;
          else          rcnt_d = rcnt_q;
        end else begin
          rcnt_d = rcnt_q + CntW'(1);
        end
`endif
      end
      StRelease: begin
        if (sync != '0) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else if (cnt_q == DebTerm) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    multi_d = multi_q;
    if (emit) begin
      valid_d = 1'b1;
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
    if (load_key) begin
      key_d   = lowest_set_index(latch_q);
      multi_d = popcount_gt1(latch_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      latch_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      key_q   <= '0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      key_q   <= key_d;
      multi_q <= multi_d;
    end
  end

  assign key_valid = valid_q;
  assign key       = key_q;
  assign multi     = multi_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_keypad_encoder;

`ifdef KEYPAD_ENCODER_KEY_REPEAT_EN
  localparam bit RepOn = 1'b1;
`else
  localparam bit RepOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cells;
  logic        key_ready;
  logic        key_valid;
  logic [3:0]  key;
  logic        multi;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  int          n_ev     = 0;
  logic [3:0]  last_key = '0;

  always #5 clk = ~clk;

  keypad_encoder #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cells    (cells),
    .key_ready(key_ready),
    .key_valid(key_valid),
    .key      (key),
    .multi    (multi),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1ns later; count transfers that happen on that edge.
  task automatic tick();
    logic       xfer;
    logic [3:0] kb;
    xfer = key_valid && key_ready;
    kb   = key;
    @(posedge clk);
    #1;
    if (xfer) begin
      n_ev++;
      last_key = kb;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_expect(input string tag, input logic [15:0] v, input logic [3:0] k,
                              input logic m);
    int e0;
    e0 = n_ev;
    tick();
    cells = v;
    ticks(6);
    check({tag, "_early"}, 32'(key_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(key_valid), 32'd1);
    check({tag, "_key"}, 32'(key), 32'(k));
    check({tag, "_multi"}, 32'(multi), 32'(m));
    tick();
    check({tag, "_one_cycle"}, 32'(key_valid), 32'd0);
    ticks(2);
    cells = '0;
    ticks(6);
    check({tag, "_busy_rel"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_events"}, 32'(n_ev - e0), 32'd1);
  endtask

  initial begin
    int  e0;
    logic stable_ok;
    rst       = 1'b1;
    cells     = '0;
    key_ready = 1'b1;
    ticks(2);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_key", 32'(key), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    ticks(3);

    press_expect("single", 16'h0020, 4'd5, 1'b0);
    ticks(4);

    // Bounce: one glitch low during early sampling yields a single event.
    e0 = n_ev;
    tick();
    cells = 16'h0020;
    ticks(2);
    cells = 16'h0000;
    tick();
    cells = 16'h0020;
    ticks(10);
    cells = 16'h0000;
    ticks(12);
    check("bounce_events", 32'(n_ev - e0), 32'd1);
    check("bounce_key", 32'(last_key), 32'd5);
    check("bounce_idle", 32'(busy), 32'd0);

    press_expect("multi", 16'h0120, 4'd5, 1'b1);
    ticks(4);
    press_expect("top", 16'h8000, 4'd15, 1'b0);
    ticks(4);

    // Backpressure: event held until consumed, next press stalls in debounce.
    key_ready = 1'b0;
    tick();
    cells = 16'h0008;
    ticks(7);
    check("bp_valid", 32'(key_valid), 32'd1);
    check("bp_key", 32'(key), 32'd3);
    stable_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!(key_valid === 1'b1 && key === 4'd3 && multi === 1'b0)) stable_ok = 1'b0;
    end
    check("bp_stable30", 32'(stable_ok), 32'd1);
    cells = 16'h0000;
    ticks(10);
    cells = 16'h4000;
    ticks(12);
    check("bp_stall_valid", 32'(key_valid), 32'd1);
    check("bp_stall_key", 32'(key), 32'd3);
    check("bp_stall_busy", 32'(busy), 32'd1);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("bp_consumed", 32'(key_valid), 32'd0);
    tick();
    check("bp_next_valid", 32'(key_valid), 32'd1);
    check("bp_next_key", 32'(key), 32'd14);
    check("bp_next_multi", 32'(multi), 32'd0);
    key_ready = 1'b1;
    tick();
    check("bp_next_taken", 32'(key_valid), 32'd0);
    cells = 16'h0000;
    ticks(12);

    // Reset during debounce, then a fresh press and optional auto-repeat.
    tick();
    cells = 16'h0001;
    ticks(4);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_key", 32'(key), 32'd0);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_multi", 32'(multi), 32'd0);
    ticks(2);
    rst = 1'b0;
    e0  = n_ev;
    ticks(6);
    check("fresh_early", 32'(key_valid), 32'd0);
    tick();
    check("fresh_valid", 32'(key_valid), 32'd1);
    check("fresh_key", 32'(key), 32'd0);
    for (int k = 8; k <= 24; k++) begin
      tick();
      if (k == 15 || k == 23) begin
        check($sformatf("rep_valid_%0d", k), 32'(key_valid), 32'(RepOn));
        if (RepOn) check($sformatf("rep_key_%0d", k), 32'(key), 32'd0);
      end
    end
    cells = 16'h0000;
    ticks(12);
    check("rep_events", 32'(n_ev - e0), RepOn ? 32'd3 : 32'd1);
    check("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
